// File: rtl/operand_entry_if.sv
// Committed-operand handshake between operand_entry (master) and its consumer (slave).
// value/clamped are stable while valid is high; the consumer raises ack to take them.
interface operand_entry_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] value;
  logic             valid;
  logic             clamped;
  logic             ack;

  modport master (output value, output valid, output clamped, input ack);
  modport slave  (input value, input valid, input clamped, output ack);
endinterface

// File: rtl/operand_entry.sv
// Push-button entry of a signed decimal operand (sign, tens, ones), encoded and saturated
// to WIDTH-bit two's complement and offered to the consumer with a valid/ack handshake.
module operand_entry #(
  parameter int WIDTH           = 6,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_next,
  input  logic                 btn_up,
  input  logic                 btn_down,
  operand_entry_if.master      bus,
  output logic [3:0]           tens,
  output logic [3:0]           ones,
  output logic                 sign_led,
  output logic [1:0]           field
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int MAX_POS = 2 ** (WIDTH - 1) - 1;
  localparam int MAX_NEG = 2 ** (WIDTH - 1);

  typedef enum logic [1:0] {
    S_SIGN = 2'd0,
    S_TENS = 2'd1,
    S_ONES = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  // Bit order: 0 = next, 1 = up, 2 = down. Raw buttons are active-low.
  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {btn_down, btn_up, btn_next};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic             sync1_q, sync1_d;
      logic             sync2_q, sync2_d;
      logic             level_q, level_d;
      logic             press_q, press_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // The counter only runs while the synchronised level disagrees with the accepted one,
      // so any bounce back to the accepted level restarts the qualification window.
      always_comb begin
        sync1_d = btn_raw[gi];
        sync2_d = sync1_q;
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
          if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        press_d = level_q & ~level_d;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync1_q <= 1'b1;
          sync2_q <= 1'b1;
          level_q <= 1'b1;
          press_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= sync1_d;
          sync2_q <= sync2_d;
          level_q <= level_d;
          press_q <= press_d;
          cnt_q   <= cnt_d;
        end
      end

      assign press[gi] = press_q;
    end
  endgenerate

  logic ev_next, ev_up, ev_dn;

  // next dominates; simultaneous up and down cancel each other.
  assign ev_next = press[0];
  assign ev_up   = press[1] & ~press[2] & ~press[0];
  assign ev_dn   = press[2] & ~press[1] & ~press[0];

  state_t           state_q, state_d;
  logic             sign_q, sign_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             valid_q, valid_d;
  logic             clamped_q, clamped_d;

  logic [6:0]       mag;
  int               mag_i;
  int               commit_i;
  logic             commit_over;

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    value_d   = value_q;
    valid_d   = valid_q;
    clamped_d = clamped_q;

    mag         = 7'(tens_q) * 7'd10 + 7'(ones_q);
    mag_i       = int'(mag);
    commit_over = sign_q ? (mag_i > MAX_NEG) : (mag_i > MAX_POS);
    if (commit_over) begin
      commit_i = sign_q ? -MAX_NEG : MAX_POS;
    end else begin
      commit_i = sign_q ? -mag_i : mag_i;
    end

    case (state_q)
      S_SIGN: begin
        if (ev_next) begin
          state_d = S_TENS;
        end else if (ev_up || ev_dn) begin
          sign_d = ~sign_q;
        end
      end
      S_TENS: begin
        if (ev_next) begin
          state_d = S_ONES;
        end else if (ev_up) begin
          tens_d = (tens_q == 4'd3) ? 4'd0 : tens_q + 4'd1;
        end else if (ev_dn) begin
          tens_d = (tens_q == 4'd0) ? 4'd3 : tens_q - 4'd1;
        end
      end
      S_ONES: begin
        if (ev_next) begin
          value_d   = commit_i[WIDTH-1:0];
          clamped_d = commit_over;
          valid_d   = 1'b1;
          state_d   = S_WAIT;
        end else if (ev_up) begin
          ones_d = (ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1;
        end else if (ev_dn) begin
          ones_d = (ones_q == 4'd0) ? 4'd9 : ones_q - 4'd1;
        end
      end
      S_WAIT: begin
        if (valid_q && bus.ack) begin
          valid_d = 1'b0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          sign_d  = 1'b0;
          state_d = S_SIGN;
        end
      end
      default: state_d = S_SIGN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_SIGN;
      sign_q    <= 1'b0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      clamped_q <= clamped_d;
    end
  end

  assign bus.value   = value_q;
  assign bus.valid   = valid_q;
  assign bus.clamped = clamped_q;
  assign tens        = tens_q;
  assign ones        = ones_q;
  assign sign_led    = sign_q;
  assign field       = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: directed scenarios followed by random button/ack traffic,
// all compared against a decimal-level model of the entry and commit rules.
module tb_operand_entry;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_next = 1'b1;
  logic       btn_up = 1'b1;
  logic       btn_down = 1'b1;
  logic       ack = 1'b0;
  logic [3:0] tens, ones;
  logic       sign_led;
  logic [1:0] field;

  operand_entry_if #(.WIDTH(6)) bus_if ();
  assign bus_if.ack = ack;

  operand_entry #(.WIDTH(6), .DEBOUNCE_CYCLES(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_next (btn_next),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .bus      (bus_if.master),
    .tens     (tens),
    .ones     (ones),
    .sign_led (sign_led),
    .field    (field)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model of what the user has keyed and what was last committed.
  int m_field, m_sign, m_tens, m_ones, m_value, m_valid, m_clamped;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_value({tag, "_field"},   32'(field),          32'(m_field));
    check_value({tag, "_sign"},    32'(sign_led),       32'(m_sign));
    check_value({tag, "_tens"},    32'(tens),           32'(m_tens));
    check_value({tag, "_ones"},    32'(ones),           32'(m_ones));
    check_value({tag, "_valid"},   32'(bus_if.valid),   32'(m_valid));
    check_value({tag, "_value"},   32'(bus_if.value),   32'(m_value));
    check_value({tag, "_clamped"}, 32'(bus_if.clamped), 32'(m_clamped));
  endtask

  task automatic model_reset();
    m_field = 0; m_sign = 0; m_tens = 0; m_ones = 0;
    m_value = 0; m_valid = 0; m_clamped = 0;
  endtask

  task automatic model_commit();
    int v;
    v = m_tens * 10 + m_ones;
    if (m_sign != 0) v = -v;
    m_clamped = 0;
    if (v > 31) begin
      v = 31; m_clamped = 1;
    end else if (v < -32) begin
      v = -32; m_clamped = 1;
    end
    m_value = (v + 64) % 64;
    m_valid = 1;
    m_field = 3;
  endtask

  task automatic model_event(input logic n, input logic u, input logic d);
    int dir;
    if (m_field == 3) return;
    if (n) begin
      if (m_field == 2) model_commit();
      else m_field = m_field + 1;
      return;
    end
    if (u == d) return;
    dir = u ? 1 : -1;
    case (m_field)
      0: m_sign = 1 - m_sign;
      1: m_tens = (m_tens + dir + 4) % 4;
      default: m_ones = (m_ones + dir + 10) % 10;
    endcase
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the chosen raw buttons low for low_cycles, then release long enough to re-debounce.
  task automatic push(input logic n, input logic u, input logic d, input int low_cycles, input string tag);
    btn_next = ~n; btn_up = ~u; btn_down = ~d;
    step(low_cycles);
    btn_next = 1'b1; btn_up = 1'b1; btn_down = 1'b1;
    step(40);
    if (low_cycles >= 19) model_event(n, u, d);
    $display("push %s n=%0b u=%0b d=%0b low=%0d -> field=%0d tens=%0d ones=%0d sign=%0b valid=%0b value=%0d",
             tag, n, u, d, low_cycles, field, tens, ones, sign_led, bus_if.valid, bus_if.value);
    check_all(tag);
  endtask

  task automatic nxt(input string tag); push(1'b1, 1'b0, 1'b0, 40, tag); endtask
  task automatic up(input string tag);  push(1'b0, 1'b1, 1'b0, 40, tag); endtask
  task automatic dn(input string tag);  push(1'b0, 1'b0, 1'b1, 40, tag); endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    if (m_valid != 0) begin
      m_valid = 0; m_tens = 0; m_ones = 0; m_sign = 0; m_field = 0;
    end
    step(1);
    $display("ack %s -> field=%0d valid=%0b value=%0d", tag, field, bus_if.valid, bus_if.value);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    model_reset();
    step(1);
    $display("reset %s -> field=%0d value=%0d", tag, field, bus_if.value);
    check_all(tag);
  endtask

  initial begin
    model_reset();
    do_reset("reset");

    // +25
    nxt("p25_sign"); up("p25_t1"); up("p25_t2"); nxt("p25_tens");
    for (int i = 0; i < 5; i++) up("p25_o");
    nxt("p25_commit");
    do_ack("p25_ack");

    // -32 exact, then -39 saturating (ones 0 -> 9 by down wrap)
    up("m32_sign"); nxt("m32_s"); up("m32_t"); up("m32_t"); up("m32_t"); nxt("m32_tn");
    up("m32_o"); up("m32_o"); nxt("m32_commit");
    do_ack("m32_ack");
    up("m39_sign"); nxt("m39_s"); up("m39_t"); up("m39_t"); up("m39_t"); nxt("m39_tn");
    dn("m39_wrap"); nxt("m39_commit");
    do_ack("m39_ack");

    // +35 saturates to +31
    nxt("p35_s"); up("p35_t"); up("p35_t"); up("p35_t"); nxt("p35_tn");
    for (int i = 0; i < 5; i++) up("p35_o");
    nxt("p35_commit");
    do_ack("p35_ack");

    // -0 encodes as zero
    up("m0_sign"); nxt("m0_s"); nxt("m0_t"); nxt("m0_commit");
    do_ack("m0_ack");

    // Wraps, cancelling up+down, next beating up, debounce rejection
    nxt("wr_s"); dn("wr_tdown0"); push(1'b0, 1'b0, 1'b0, 5, "wr_none");
    push(1'b0, 1'b1, 1'b0, 5, "bounce5");
    push(1'b0, 1'b1, 1'b1, 40, "updn_tens");
    push(1'b1, 1'b1, 1'b0, 40, "next_wins");
    dn("wr_o9"); up("wr_o0"); push(1'b0, 1'b1, 1'b1, 40, "updn_ones");
    push(1'b0, 1'b1, 1'b0, 40, "held40");
    nxt("wr_commit");

    // Events during WAIT_ACK are ignored
    up("wait_up"); dn("wait_dn"); nxt("wait_next");
    do_ack("wait_ack");
    do_ack("ack_idle");

    // Reset mid-entry in ONES with 27
    nxt("rs_s"); up("rs_t"); up("rs_t"); nxt("rs_tn");
    for (int i = 0; i < 7; i++) up("rs_o");
    do_reset("reset_mid");

    // Random traffic
    for (int k = 0; k < 200; k++) begin
      int r;
      r = $urandom_range(0, 11);
      if (m_field == 3 && $urandom_range(0, 2) == 0) do_ack("rnd_ack");
      else if (r <= 2) up("rnd_up");
      else if (r <= 4) dn("rnd_dn");
      else if (r <= 7) nxt("rnd_next");
      else if (r == 8) push(1'b0, 1'b1, 1'b1, 40, "rnd_updn");
      else if (r == 9) push(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 40, "rnd_nextmix");
      else if (r == 10) push(1'b0, 1'b1, 1'b0, $urandom_range(1, 12), "rnd_bounce");
      else do_ack("rnd_ack_any");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
